// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared constants and types for the AES-256 stream controller.
//   AES_LAT        - pipeline latency of the 14-round AES-256 datapath
//   AES_BW         - cipher block width
//   ID_W           - requester tag width (two requesters)
//   fifo_entry_t   - {ciphertext, requester id} as stored in the output FIFO
//   shadow_entry_t - {valid, requester id} tracking one pipeline stage
//   rr_ptr_t       - round-robin pointer (which requester wins a tie)
package aes_ctrl_pkg;

    localparam int unsigned AES_LAT = 14;
    localparam int unsigned AES_BW  = 128;
    localparam int unsigned ID_W    = 1;

    typedef struct packed {
        logic [AES_BW-1:0] data;
        logic [ID_W-1:0]   id;
    } fifo_entry_t;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } shadow_entry_t;

    typedef enum logic [ID_W-1:0] {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/aes_ctrl_fifo.sv
// aes_ctrl_fifo: synchronous FIFO, registered storage, head shown combinationally.
//   clk, rst_n   - clock, asynchronous active-low reset (pointers only)
//   push, push_data - write an entry at the closing edge
//   pop          - retire the head entry at the closing edge (ignored when empty)
//   head_data    - current head entry, all-zero while empty
//   full, empty  - occupancy flags
//   count        - number of stored entries
// DEPTH is expected to be a power of two: read/write pointers carry one extra
// wrap bit and wrap modulo 2*DEPTH, which distinguishes full from empty.
module aes_ctrl_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 129
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  ptr_diff;

    assign ptr_diff = wr_ptr - rd_ptr;
    assign count    = CW'(ptr_diff);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Zero while empty so the output bus reads zero after reset without
    // having to reset the storage array itself.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: front-end scheduler for the AES-256 encryption pipeline.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req0_* / req1_*     - two valid/ready plaintext requesters
//   aes_pt              - plaintext to the pipeline (all-zero bubble when idle)
//   aes_ct              - ciphertext returning LAT cycles after aes_pt
//   out_valid/ready/data/id - tagged ciphertext result stream, issue order
//   in_flight           - blocks issued but not yet captured in the FIFO
// A block is issued only while in-flight plus buffered blocks stay below
// DEPTH, so every returning ciphertext always has a FIFO slot waiting.
module aes_stream_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned LAT   = AES_LAT,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned BW    = AES_BW
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req0_valid,
    input  logic [BW-1:0]                req0_data,
    output logic                         req0_ready,
    input  logic                         req1_valid,
    input  logic [BW-1:0]                req1_data,
    output logic                         req1_ready,
    output logic [BW-1:0]                aes_pt,
    input  logic [BW-1:0]                aes_ct,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BW-1:0]                out_data,
    output logic [ID_W-1:0]              out_id,
    output logic [$clog2(DEPTH+1)-1:0]   in_flight
);

    localparam int unsigned  CW         = $clog2(DEPTH+1);
    localparam int unsigned  EW         = BW + ID_W;
    localparam logic [CW:0]  CREDIT_MAX = (CW+1)'(DEPTH);

    rr_ptr_t         rr_ptr;
    rr_ptr_t         rr_ptr_next;
    shadow_entry_t   shadow [LAT];

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_sum;
    logic            credit_ok;
    logic            grant0;
    logic            grant1;
    logic [ID_W-1:0] grant_id;
    logic            issue;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   push_entry;
    logic [EW-1:0]   head_entry;

    // Credit uses registered counts only; a pop in this cycle frees its slot
    // for issue from the next cycle on.
    assign credit_sum = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok  = (credit_sum < CREDIT_MAX);

    // Two-way round robin: a lone requester wins outright, a tie goes to
    // the pointer side.
    always_comb begin
        grant0      = req0_valid & (~req1_valid | (rr_ptr == RR_REQ0));
        grant1      = req1_valid & (~req0_valid | (rr_ptr == RR_REQ1));
        grant_id    = ID_W'(grant1);
        issue       = credit_ok & (grant0 | grant1);
        req0_ready  = credit_ok & grant0;
        req1_ready  = credit_ok & grant1;
        aes_pt      = '0;
        if (issue) begin
            aes_pt = grant1 ? req1_data : req0_data;
        end
        rr_ptr_next = rr_ptr;
        if (issue) begin
            rr_ptr_next = grant1 ? RR_REQ0 : RR_REQ1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= RR_REQ0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Shadow of the datapath: clearing it on reset is what discards blocks
    // still travelling through the unresettable AES stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            shadow[0] <= '{v: issue, id: grant_id};
            for (int unsigned i = 1; i < LAT; i++) begin
                shadow[i] <= shadow[i-1];
            end
        end
    end

    assign push       = shadow[LAT-1].v;
    assign push_entry = {aes_ct, shadow[LAT-1].id};
    assign out_valid  = ~fifo_empty;
    assign pop        = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else if (issue && !push) begin
            in_flight <= in_flight + 1'b1;
        end else if (!issue && push) begin
            in_flight <= in_flight - 1'b1;
        end
    end

    aes_ctrl_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {out_data, out_id} = head_entry;

    // Credit makes a push into a full FIFO impossible unless a pop frees
    // the slot in the same cycle.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop)
    );

endmodule
